// File: rtl/dense_score_engine.sv
// ---------------------------------------------------------------------------
// dense_score_engine
//   Single dense layer scorer: streams N_IN pixels from an external
//   combinational-read image memory, multiplies each pixel by one signed
//   weight per class and accumulates all N_CLASSES scores in parallel.
//   The class with the largest score is then found with a one-class-per-cycle
//   scan and reported.
//
//   Per-inference timeline (A = edge that accepts start):
//     ACCUM  : N_IN cycles, pix_addr = pixel counter
//     ARGMAX : N_CLASSES cycles
//     DONE   : 1 cycle, done=1, pred_valid/pred_class already updated
//     IDLE   : start accepted again
//
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : request an inference, only looked at in IDLE
//   pix_addr    : pixel index (0 outside ACCUM)
//   pix_data    : unsigned pixel at pix_addr, same cycle
//   wgt_data    : per-class signed weights for pix_addr, class k at [k*WGT_W +: WGT_W]
//   busy        : high in ACCUM and ARGMAX
//   done        : one-cycle completion pulse
//   scores      : registered signed scores, class k at [k*ACC_W +: ACC_W]
//   pred_class  : index of the maximum score (lowest index on ties)
//   pred_valid  : scores/pred_class belong to the last completed inference
// ---------------------------------------------------------------------------

// One class lane: acc + sext(pixel * weight), wrapping or clamping.
module dense_score_lane #(
    parameter int PIX_W    = 8,
    parameter int WGT_W    = 8,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic [PIX_W-1:0] pix,
    input  logic [WGT_W-1:0] wgt,
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] sum
);
    localparam int PROD_W = PIX_W + WGT_W + 1;
    localparam int SUM_W  = ACC_W + 1;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  wide;
    logic                     ovf;

    always_comb begin
        // Pixel is unsigned: prepend a zero so the signed multiply treats it as positive.
        prod = PROD_W'($signed({1'b0, pix})) * PROD_W'($signed(wgt));
        // One guard bit is enough to see overflow of a single add.
        wide = SUM_W'(prod) + SUM_W'($signed(acc));
        ovf  = wide[ACC_W] ^ wide[ACC_W-1];
        if ((SATURATE != 0) && ovf)
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = wide[ACC_W-1:0];
    end
endmodule

module dense_score_engine #(
    parameter int N_IN      = 784,
    parameter int N_CLASSES = 10,
    parameter int PIX_W     = 8,
    parameter int WGT_W     = 8,
    parameter int ACC_W     = 32,
    parameter int SATURATE  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [31:0]                   pix_addr,
    input  logic [PIX_W-1:0]              pix_data,
    input  logic [N_CLASSES*WGT_W-1:0]    wgt_data,
    output logic                          busy,
    output logic                          done,
    output logic [N_CLASSES*ACC_W-1:0]    scores,
    output logic [$clog2(N_CLASSES)-1:0]  pred_class,
    output logic                          pred_valid
);
    localparam int IDX_W = $clog2(N_CLASSES);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ARGMAX, S_DONE} state_t;

    state_t                            state_q, state_d;
    logic [31:0]                       cnt_q, cnt_d;
    logic [N_CLASSES-1:0][ACC_W-1:0]   score_q, score_d;
    logic [N_CLASSES-1:0][ACC_W-1:0]   lane_sum;
    logic [IDX_W-1:0]                  best_idx_q, best_idx_d;
    logic [ACC_W-1:0]                  best_val_q, best_val_d;
    logic [IDX_W-1:0]                  pred_class_q, pred_class_d;
    logic                              pred_valid_q, pred_valid_d;

    logic [IDX_W-1:0]                  scan_idx;
    logic [ACC_W-1:0]                  scan_val;
    logic                              scan_take;
    logic                              accum_last, scan_last;

    // Per-class MAC lanes
    for (genvar g = 0; g < N_CLASSES; g++) begin : g_lane
        dense_score_lane #(
            .PIX_W   (PIX_W),
            .WGT_W   (WGT_W),
            .ACC_W   (ACC_W),
            .SATURATE(SATURATE)
        ) u_lane (
            .pix(pix_data),
            .wgt(wgt_data[g*WGT_W +: WGT_W]),
            .acc(score_q[g]),
            .sum(lane_sum[g])
        );
    end

    assign accum_last = (cnt_q == 32'(N_IN - 1));
    assign scan_last  = (cnt_q == 32'(N_CLASSES - 1));
    assign scan_idx   = cnt_q[IDX_W-1:0];
    assign scan_val   = score_q[scan_idx];
    // First class seeds the running max; strict > keeps the lowest index on ties.
    assign scan_take  = (cnt_q == 32'd0) || ($signed(scan_val) > $signed(best_val_q));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            score_q      <= '0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            score_q      <= score_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            pred_class_q <= pred_class_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)      state_d = S_ACCUM;
            S_ACCUM:  if (accum_last) state_d = S_ARGMAX;
            S_ARGMAX: if (scan_last)  state_d = S_DONE;
            S_DONE:                   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Datapath / register updates
    always_comb begin
        cnt_d        = cnt_q;
        score_d      = score_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        pred_class_d = pred_class_q;
        pred_valid_d = pred_valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d        = '0;
                    score_d      = '0;
                    pred_valid_d = 1'b0;
                end
            end
            S_ACCUM: begin
                score_d = lane_sum;
                cnt_d   = accum_last ? 32'd0 : cnt_q + 32'd1;
            end
            S_ARGMAX: begin
                if (scan_take) begin
                    best_idx_d = scan_idx;
                    best_val_d = scan_val;
                end
                cnt_d = cnt_q + 32'd1;
                if (scan_last) begin
                    // Result is visible during the DONE cycle alongside done.
                    pred_class_d = scan_take ? scan_idx : best_idx_q;
                    pred_valid_d = 1'b1;
                    cnt_d        = '0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
        done       = (state_q == S_DONE);
        pix_addr   = (state_q == S_ACCUM) ? cnt_q : 32'd0;
        scores     = score_q;
        pred_class = pred_class_q;
        pred_valid = pred_valid_q;
    end
endmodule

// File: tb/tb_dense_score_engine.sv
// Testbench for dense_score_engine: two small instances (wrap / saturate)
// and one default-parameter instance. Expected results go into per-instance
// queues when start is issued; monitors pop and compare on every done.
module tb_dense_score_engine;
    localparam int BN = 784;
    localparam int BC = 10;

    typedef struct packed {
        logic [9:0][31:0] sc;
        logic [31:0]      pred;
        logic [31:0]      acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    logic rst, st0, st1, st2;

    // small image shared by u0/u1, big image for u2
    logic [7:0]  img [4];
    logic [23:0] wgt [4];
    logic [7:0]  bimg [BN];
    logic [79:0] bwgt [BN];

    logic [31:0] pa0, pa1, pa2;
    logic [7:0]  pd0, pd1, pd2;
    logic [23:0] wd0, wd1;
    logic [79:0] wd2;
    logic        by0, by1, by2, dn0, dn1, dn2, pv0, pv1, pv2;
    logic [47:0] sc0, sc1;
    logic [319:0] sc2;
    logic [1:0]  pc0, pc1;
    logic [3:0]  pc2;

    assign pd0 = (pa0 < 4) ? img[pa0[1:0]] : 8'h0;
    assign wd0 = (pa0 < 4) ? wgt[pa0[1:0]] : 24'h0;
    assign pd1 = (pa1 < 4) ? img[pa1[1:0]] : 8'h0;
    assign wd1 = (pa1 < 4) ? wgt[pa1[1:0]] : 24'h0;
    assign pd2 = (pa2 < BN) ? bimg[pa2] : 8'h0;
    assign wd2 = (pa2 < BN) ? bwgt[pa2] : 80'h0;

    dense_score_engine #(.N_IN(4), .N_CLASSES(3), .PIX_W(8), .WGT_W(8), .ACC_W(16), .SATURATE(0)) u0 (
        .clk(clk), .reset(rst), .start(st0), .pix_addr(pa0), .pix_data(pd0), .wgt_data(wd0),
        .busy(by0), .done(dn0), .scores(sc0), .pred_class(pc0), .pred_valid(pv0));
    dense_score_engine #(.N_IN(4), .N_CLASSES(3), .PIX_W(8), .WGT_W(8), .ACC_W(16), .SATURATE(1)) u1 (
        .clk(clk), .reset(rst), .start(st1), .pix_addr(pa1), .pix_data(pd1), .wgt_data(wd1),
        .busy(by1), .done(dn1), .scores(sc1), .pred_class(pc1), .pred_valid(pv1));
    dense_score_engine u2 (
        .clk(clk), .reset(rst), .start(st2), .pix_addr(pa2), .pix_data(pd2), .wgt_data(wd2),
        .busy(by2), .done(dn2), .scores(sc2), .pred_class(pc2), .pred_valid(pv2));

    exp_t q0[$], q1[$], q2[$];

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input int c, input int p, input int acc);
        exp_t e;
        e = '0;
        e.sc[0] = a; e.sc[1] = b; e.sc[2] = c;
        e.pred = p; e.acc = acc;
        return e;
    endfunction

    task automatic ld_pix(input int a, input int b, input int c, input int d);
        img[0] = 8'(a); img[1] = 8'(b); img[2] = 8'(c); img[3] = 8'(d);
    endtask

    task automatic ld_cls(input int k, input int a, input int b, input int c, input int d);
        wgt[0][k*8 +: 8] = 8'(a); wgt[1][k*8 +: 8] = 8'(b);
        wgt[2][k*8 +: 8] = 8'(c); wgt[3][k*8 +: 8] = 8'(d);
    endtask

    task automatic ld_basic();
        ld_pix(1, 2, 3, 4);
        ld_cls(0, 1, 1, 1, 1);
        ld_cls(1, -1, -1, -1, -1);
        ld_cls(2, 0, 0, 0, 10);
    endtask

    // One start pulse on u0, then idle long enough for the result.
    task automatic run0(input int a, input int b, input int c, input int p);
        @(negedge clk);
        q0.push_back(mk(a, b, c, p, cyc + 1));
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Monitors: done is seen in the cycle ending at edge accept+N_IN+N_CLASSES+1.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (dn0) begin
            if (q0.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL u0_done unexpected at cycle %0d, required no done", cyc);
            end else begin
                e = q0.pop_front();
                chk("u0_latency", cyc + 1 - int'(e.acc), 8);
                for (int k = 0; k < 3; k++)
                    chk($sformatf("u0_score%0d", k), int'($signed(sc0[k*16 +: 16])), int'(e.sc[k]));
                chk("u0_pred_class", int'(pc0), int'(e.pred));
                chk("u0_pred_valid", int'(pv0), 1);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (dn1) begin
            if (q1.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL u1_done unexpected at cycle %0d, required no done", cyc);
            end else begin
                e = q1.pop_front();
                chk("u1_latency", cyc + 1 - int'(e.acc), 8);
                for (int k = 0; k < 3; k++)
                    chk($sformatf("u1_score%0d", k), int'($signed(sc1[k*16 +: 16])), int'(e.sc[k]));
                chk("u1_pred_class", int'(pc1), int'(e.pred));
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (dn2) begin
            if (q2.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL u2_done unexpected at cycle %0d, required no done", cyc);
            end else begin
                e = q2.pop_front();
                chk("u2_latency", cyc + 1 - int'(e.acc), BN + BC + 1);
                for (int k = 0; k < BC; k++)
                    chk($sformatf("u2_score%0d", k), int'($signed(sc2[k*32 +: 32])), int'(e.sc[k]));
                chk("u2_pred_class", int'(pc2), int'(e.pred));
            end
        end
    end

    initial begin
        exp_t be;
        int   a, nbusy;
        logic signed [7:0] ws;

        rst = 1'b1; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        ld_basic();

        // big image and its golden scores
        be = '0;
        for (int i = 0; i < BN; i++) begin
            bimg[i] = 8'((i * 37 + 11) % 256);
            for (int k = 0; k < BC; k++) begin
                ws = 8'((i * 13 + k * 29 + 5) % 256);
                bwgt[i][k*8 +: 8] = ws;
                be.sc[k] = 32'(int'(be.sc[k]) + int'(bimg[i]) * int'(ws));
            end
        end
        be.pred = 0;
        for (int k = 1; k < BC; k++)
            if ($signed(be.sc[k]) > $signed(be.sc[be.pred])) be.pred = k;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(by0), 0);
        chk("rst_done", int'(dn0), 0);
        chk("rst_pred_valid", int'(pv0), 0);
        chk("rst_pred_class", int'(pc0), 0);
        chk("rst_pix_addr", int'(pa0), 0);
        chk("rst_scores_zero", int'(sc0 == 48'h0), 1);
        rst = 1'b0;

        // basic, tie, signed argmax over all-negative scores
        run0(10, -10, 40, 2);
        chk("idle_pred_valid_held", int'(pv0), 1);
        chk("idle_pix_addr", int'(pa0), 0);
        chk("idle_busy", int'(by0), 0);
        ld_pix(5, 5, 5, 5);
        ld_cls(0, 3, 3, 3, 3); ld_cls(1, 3, 3, 3, 3); ld_cls(2, 3, 3, 3, 3);
        run0(60, 60, 60, 0);
        ld_pix(1, 2, 3, 4);
        ld_cls(0, -5, -5, -5, -5); ld_cls(1, -1, -1, -1, -1); ld_cls(2, -3, -3, -3, -3);
        run0(-50, -10, -30, 1);

        // reset in the second ACCUM cycle, then a clean run
        ld_basic();
        @(negedge clk); st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", int'(by0), 0);
        chk("midrst_scores_zero", int'(sc0 == 48'h0), 1);
        chk("midrst_pred_valid", int'(pv0), 0);
        chk("midrst_pix_addr", int'(pa0), 0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done_pending", q0.size(), 0);
        run0(10, -10, 40, 2);

        // start pulses while busy and during DONE are ignored
        @(negedge clk);
        a = cyc + 1;
        q0.push_back(mk(10, -10, 40, 2, a));
        st0 = 1'b1;
        @(negedge clk); st0 = 1'b0;
        while (cyc != a + 2) @(negedge clk);
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        while (cyc != a + 5) @(negedge clk);
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        while (cyc != a + 7) @(negedge clk);
        st0 = 1'b1; @(negedge clk); st0 = 1'b0;
        repeat (14) @(negedge clk);

        // start held high: three back-to-back inferences, 9 cycles apart
        @(negedge clk);
        a = cyc + 1;
        q0.push_back(mk(10, -10, 40, 2, a));
        q0.push_back(mk(10, -10, 40, 2, a + 9));
        q0.push_back(mk(10, -10, 40, 2, a + 18));
        st0 = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (by0) nbusy++;
            if (i == 19) st0 = 1'b0;
        end
        chk("b2b_busy_cycles", nbusy, 21);
        repeat (6) @(negedge clk);

        // overflow: wrap on u0, clamp on u1
        ld_pix(255, 255, 255, 255);
        ld_cls(0, 127, 127, 127, 127); ld_cls(1, 0, 0, 0, 0); ld_cls(2, -128, -128, -128, -128);
        @(negedge clk);
        q0.push_back(mk(-1532, 0, 512, 2, cyc + 1));
        q1.push_back(mk(32767, 0, -32768, 0, cyc + 1));
        st0 = 1'b1; st1 = 1'b1;
        @(negedge clk); st0 = 1'b0; st1 = 1'b0;
        repeat (12) @(negedge clk);

        // default parameters against the golden model
        @(negedge clk);
        be.acc = cyc + 1;
        q2.push_back(be);
        st2 = 1'b1;
        @(negedge clk); st2 = 1'b0;
        repeat (BN + BC + 10) @(negedge clk);
        chk("u2_pred_valid", int'(pv2), 1);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
